hue_stage2_pipe: RTL and testbench
==================================

Name: hue_stage2_pipe

Overview:
Parametrised second stage of the hue datapath, replacing the fixed-width, always-ready stage 2.
- Takes the signed normalised chroma ratio from stage 1 and the max-channel function code.
- Scales the ratio by 60, rounds it, adds the sector offset and wraps the result into 0..359 degrees.
- Three-stage pipeline with valid/ready backpressure, sideband passthrough, clamp and gray flags; feeds the colour-threshold block.

Parameters:
DATA_W, 16, width of signed i_data (two's complement)
FRAC_W, 6, fractional bits of i_data; 1.0 = 2^FRAC_W
HUE_W, 9, width of unsigned o_data (must hold 359)
USER_W, 8, sideband width carried alongside each sample

Ports:
i_clk  in  1  clock
i_rstn  in  1  asynchronous active-low reset
i_data  in  DATA_W  signed ratio, FRAC_W fractional bits
i_function  in  2  0=gray/undefined, 1=R max (offset 0), 2=G max (offset 120), 3=B max (offset 240)
i_user  in  USER_W  sideband, passed through unchanged
i_valid  in  1  input sample valid
o_ready  out  1  stage accepts input this cycle
o_data  out  HUE_W  hue in integer degrees, 0..359
o_user  out  USER_W  sideband aligned with o_data
o_gray  out  1  sample had function 0
o_clamp  out  1  input magnitude exceeded 1.0 and was clamped
o_valid  out  1  output valid
i_ready  in  1  downstream accepts output

Behaviour:
- One clock, i_clk. Reset is asynchronous, active-low, on i_rstn.
- Reset state: all stage valids 0. o_valid, o_data, o_user, o_gray and o_clamp are 0. o_ready is 1 after reset.
- Pipeline advance: adv = ~o_valid | i_ready; o_ready = adv, combinational.
- When adv=1, every stage shifts by one. When adv=0, every stage holds. Bubbles are not collapsed.
- Input transfer occurs on i_valid & o_ready. Latency is 3 cycles from transfer to o_valid with no stall.
- Throughput is 1 sample per cycle.
- Output hold: while o_valid=1 and i_ready=0, o_data, o_user, o_gray and o_clamp stay stable.
- Stage 1 (clamp and multiply):
  - If i_data > 2^FRAC_W, clamp to +2^FRAC_W and set clamp=1.
  - If i_data < -2^FRAC_W, clamp to -2^FRAC_W and set clamp=1.
  - prod = clamped * 60, signed, width DATA_W+7.
- Stage 2 (round and offset):
  - deg = (prod + 2^(FRAC_W-1)) >>> FRAC_W. This is an arithmetic shift: round half toward +infinity.
  - sum = deg + offset(function), signed, range -60..300.
- Stage 3 (wrap):
  - If sum < 0, output sum + 360; else if sum >= 360, output sum - 360; else output sum.
  - function 0 forces o_data = 0 and o_gray = 1, and sets o_clamp = 0.
- Samples with i_valid=0 create bubbles. Bubble stage data is don't-care, but o_valid must be 0 for a bubble.
- Reset asserted mid-operation: all in-flight samples are discarded immediately, valids clear, and no partial output appears.
- Simultaneous input transfer and output transfer in the same cycle is legal when full and i_ready=1.

Optional Feature:
HUE_STAGE2_STATS_EN
- Defined:
  - Adds input i_clr_stats (1 bit).
  - Adds outputs o_gray_cnt and o_clamp_cnt, 16 bits each.
  - Each counter increments on an output transfer (o_valid & i_ready) with the corresponding flag set.
  - Counters saturate at 0xFFFF.
  - i_clr_stats zeroes both counters synchronously and takes priority over a same-cycle increment.
  - Counters reset to 0.
- Undefined: ports and counters are absent; the datapath is identical.

Test Plan:
- Reset, then i_data=32, function=1, i_ready=1 -> o_valid exactly 3 cycles later, o_data=30, o_gray=0, o_clamp=0.
- Wrap and offset cases, back-to-back -> outputs 330, 60, 300, 359 in order on consecutive cycles:
  - i_data=-32, fn=1 -> 330
  - i_data=-64, fn=2 -> 60
  - i_data=64, fn=3 -> 300
  - i_data=-1, fn=1 -> 359
- Flag cases:
  - i_data=100, fn=1 -> o_data=60, o_clamp=1.
  - i_data=-500, fn=3 -> o_data=180, o_clamp=1.
  - i_data=17, fn=0 -> o_data=0, o_gray=1.
- Backpressure: stream 6 samples with i_user=0..5 while holding i_ready=0 for 5 cycles after the first o_valid ->
  - o_ready drops once the pipe is full.
  - o_data holds stable during the stall.
  - All 6 samples emerge in order with matching o_user; none are lost or duplicated.
- Reset mid-stream: assert i_rstn=0 with 3 samples in flight -> o_valid=0 immediately (asynchronous).
  - No stale output appears after release.
  - The next sample (32, fn=2) -> o_data=150.
- With HUE_STAGE2_STATS_EN: send 3 gray and 2 clamped samples -> o_gray_cnt=3, o_clamp_cnt=2.
  - i_clr_stats pulse coincident with a gray output transfer -> o_gray_cnt=0.

Source files
------------

// File: rtl/hue_stage2_pipe_if.sv
// ============================================================================
// hue_stage2_pipe_if : valid/ready stream bundle for hue stage 2
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface hue_stage2_pipe_if #(
  parameter int DATA_W = 16,
  parameter int HUE_W  = 9,
  parameter int USER_W = 8
);
  logic signed [DATA_W-1:0] i_data;
  logic [1:0]               i_function;
  logic [USER_W-1:0]        i_user;
  logic                     i_valid;
  logic                     o_ready;
  logic [HUE_W-1:0]         o_data;
  logic [USER_W-1:0]        o_user;
  logic                     o_gray;
  logic                     o_clamp;
  logic                     o_valid;
  logic                     i_ready;

  // master is the upstream source and downstream sink; slave is the stage
  modport master (
    output i_data, i_function, i_user, i_valid, i_ready,
    input  o_ready, o_data, o_user, o_gray, o_clamp, o_valid
  );

  modport slave (
    input  i_data, i_function, i_user, i_valid, i_ready,
    output o_ready, o_data, o_user, o_gray, o_clamp, o_valid
  );
endinterface

`default_nettype wire

// File: rtl/hue_stage2_pipe.sv
// ============================================================================
// hue_stage2_pipe : ratio*60, round, sector offset, wrap to 0..359 (3 stages)
// Optional counters: define HUE_STAGE2_STATS_EN
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module hue_stage2_pipe #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 6,
  parameter int HUE_W  = 9,
  parameter int USER_W = 8
) (
  input  logic        i_clk,
  input  logic        i_rstn,
`ifdef HUE_STAGE2_STATS_EN
  input  logic        i_clr_stats,
  output logic [15:0] o_gray_cnt,
  output logic [15:0] o_clamp_cnt,
`endif
  hue_stage2_pipe_if.slave bus
);

  localparam int c_PROD_W = DATA_W + 7;
  localparam int c_SUM_W  = HUE_W + 2;

  localparam logic signed [DATA_W-1:0]   c_ONE     = DATA_W'(1 << FRAC_W);
  localparam logic signed [DATA_W-1:0]   c_NEG_ONE = -c_ONE;
  localparam logic signed [c_PROD_W-1:0] c_SIXTY   = c_PROD_W'(60);
  localparam logic signed [c_PROD_W-1:0] c_HALF    = c_PROD_W'(1 << (FRAC_W - 1));
  localparam logic signed [c_PROD_W-1:0] c_OFF_G   = c_PROD_W'(120);
  localparam logic signed [c_PROD_W-1:0] c_OFF_B   = c_PROD_W'(240);
  localparam logic signed [c_SUM_W-1:0]  c_FULL    = c_SUM_W'(360);

  logic                       w_adv;

  logic signed [DATA_W-1:0]   w_clamped;
  logic                       s1_clamp_d;
  logic signed [c_PROD_W-1:0] s1_prod_d;
  logic                       s1_valid_q;
  logic                       s1_clamp_q;
  logic signed [c_PROD_W-1:0] s1_prod_q;
  logic [1:0]                 s1_fn_q;
  logic [USER_W-1:0]          s1_user_q;

  logic signed [c_PROD_W-1:0] w_deg;
  logic signed [c_PROD_W-1:0] w_offset;
  logic signed [c_SUM_W-1:0]  s2_sum_d;
  logic signed [c_SUM_W-1:0]  s2_sum_q;
  logic                       s2_valid_q;
  logic                       s2_gray_q;
  logic                       s2_clamp_q;
  logic [USER_W-1:0]          s2_user_q;

  logic signed [c_SUM_W-1:0]  w_wrap;
  logic [HUE_W-1:0]           out_data_d;
  logic [HUE_W-1:0]           out_data_q;
  logic [USER_W-1:0]          out_user_q;
  logic                       out_valid_q;
  logic                       out_gray_q;
  logic                       out_clamp_q;

  // Whole pipe moves in lockstep; bubbles are kept, so only the output stage gates it
  assign w_adv       = ~out_valid_q | bus.i_ready;
  assign bus.o_ready = w_adv;

  always_comb begin
    w_clamped  = bus.i_data;
    s1_clamp_d = 1'b0;
    if (bus.i_data > c_ONE) begin
      w_clamped  = c_ONE;
      s1_clamp_d = 1'b1;
    end else if (bus.i_data < c_NEG_ONE) begin
      w_clamped  = c_NEG_ONE;
      s1_clamp_d = 1'b1;
    end
  end

  assign s1_prod_d = $signed({{7{w_clamped[DATA_W-1]}}, w_clamped}) * c_SIXTY;

  // Arithmetic shift after adding one half rounds ties toward +infinity
  assign w_deg = (s1_prod_q + c_HALF) >>> FRAC_W;

  always_comb begin
    case (s1_fn_q)
      2'd2:    w_offset = c_OFF_G;
      2'd3:    w_offset = c_OFF_B;
      default: w_offset = '0;
    endcase
  end

  assign s2_sum_d = c_SUM_W'(w_deg + w_offset);

  always_comb begin
    w_wrap = s2_sum_q;
    if (s2_sum_q[c_SUM_W-1]) begin
      w_wrap = s2_sum_q + c_FULL;
    end else if (s2_sum_q >= c_FULL) begin
      w_wrap = s2_sum_q - c_FULL;
    end
    out_data_d = s2_gray_q ? '0 : HUE_W'(w_wrap);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_valid_q  <= 1'b0;
      s1_clamp_q  <= 1'b0;
      s1_prod_q   <= '0;
      s1_fn_q     <= '0;
      s1_user_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_gray_q   <= 1'b0;
      s2_clamp_q  <= 1'b0;
      s2_sum_q    <= '0;
      s2_user_q   <= '0;
      out_valid_q <= 1'b0;
      out_gray_q  <= 1'b0;
      out_clamp_q <= 1'b0;
      out_data_q  <= '0;
      out_user_q  <= '0;
    end else if (w_adv) begin
      s1_valid_q  <= bus.i_valid;
      s1_clamp_q  <= s1_clamp_d;
      s1_prod_q   <= s1_prod_d;
      s1_fn_q     <= bus.i_function;
      s1_user_q   <= bus.i_user;
      s2_valid_q  <= s1_valid_q;
      s2_gray_q   <= (s1_fn_q == 2'd0);
      s2_clamp_q  <= s1_clamp_q & (s1_fn_q != 2'd0);
      s2_sum_q    <= s2_sum_d;
      s2_user_q   <= s1_user_q;
      out_valid_q <= s2_valid_q;
      out_gray_q  <= s2_gray_q;
      out_clamp_q <= s2_clamp_q;
      out_data_q  <= out_data_d;
      out_user_q  <= s2_user_q;
    end
  end

  assign bus.o_valid = out_valid_q;
  assign bus.o_data  = out_data_q;
  assign bus.o_user  = out_user_q;
  assign bus.o_gray  = out_gray_q;
  assign bus.o_clamp = out_clamp_q;

`ifdef HUE_STAGE2_STATS_EN
  logic        w_out_xfer;
  logic [15:0] gray_cnt_q;
  logic [15:0] clamp_cnt_q;

  assign w_out_xfer = out_valid_q & bus.i_ready;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      gray_cnt_q  <= '0;
      clamp_cnt_q <= '0;
    end else if (i_clr_stats) begin
      gray_cnt_q  <= '0;
      clamp_cnt_q <= '0;
    end else if (w_out_xfer) begin
      if (out_gray_q && (gray_cnt_q != 16'hFFFF)) begin
        gray_cnt_q <= gray_cnt_q + 16'd1;
      end
      if (out_clamp_q && (clamp_cnt_q != 16'hFFFF)) begin
        clamp_cnt_q <= clamp_cnt_q + 16'd1;
      end
    end
  end

  assign o_gray_cnt  = gray_cnt_q;
  assign o_clamp_cnt = clamp_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hue_stage2_pipe.sv
// ============================================================================
// tb_hue_stage2_pipe : directed vectors, scoreboard model and literal checks
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hue_stage2_pipe;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 6;
  localparam int HUE_W  = 9;
  localparam int USER_W = 8;

  typedef struct {
    int data;
    int user;
    int gray;
    int clamp;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  hue_stage2_pipe_if #(.DATA_W(DATA_W), .HUE_W(HUE_W), .USER_W(USER_W)) bus ();

`ifdef HUE_STAGE2_STATS_EN
  logic        clr_stats;
  logic [15:0] gray_cnt;
  logic [15:0] clamp_cnt;
`endif

  hue_stage2_pipe #(
    .DATA_W(DATA_W), .FRAC_W(FRAC_W), .HUE_W(HUE_W), .USER_W(USER_W)
  ) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
`ifdef HUE_STAGE2_STATS_EN
    .i_clr_stats(clr_stats),
    .o_gray_cnt (gray_cnt),
    .o_clamp_cnt(clamp_cnt),
`endif
    .bus        (bus)
  );

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t exp_q[$];
  exp_t obs_q[$];
  int   obs_cyc[$];

  task automatic check(string name, int act, int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference hue: clamp to +-1.0, degrees = floor(ratio*60 + 0.5), offset, modulo 360
  function automatic exp_t model(int d, int fn, int u);
    exp_t e;
    int   one;
    int   c;
    int   deg;
    int   sum;
    one     = 1 << FRAC_W;
    c       = d;
    e.user  = u;
    e.gray  = 0;
    e.clamp = 0;
    if (d > one) begin
      c = one;
      e.clamp = 1;
    end else if (d < -one) begin
      c = -one;
      e.clamp = 1;
    end
    deg = $rtoi($floor((real'(c) * 60.0 + real'(one) / 2.0) / real'(one)));
    if (fn == 0) begin
      e.data  = 0;
      e.gray  = 1;
      e.clamp = 0;
    end else begin
      sum    = deg + 120 * (fn - 1);
      e.data = ((sum % 360) + 360) % 360;
    end
    return e;
  endfunction

  exp_t             mon_e;
  exp_t             mon_o;
  bit               prev_stall = 1'b0;
  logic [HUE_W-1:0] prev_data;
  logic [USER_W-1:0] prev_user;
  logic             prev_gray;
  logic             prev_clamp;

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("o_ready_rule", int'(bus.o_ready), int'(!bus.o_valid || bus.i_ready));
      if (prev_stall) begin
        check("hold_valid", int'(bus.o_valid), 1);
        check("hold_data",  int'(bus.o_data),  int'(prev_data));
        check("hold_user",  int'(bus.o_user),  int'(prev_user));
        check("hold_gray",  int'(bus.o_gray),  int'(prev_gray));
        check("hold_clamp", int'(bus.o_clamp), int'(prev_clamp));
      end
      if (bus.o_valid && bus.i_ready) begin
        mon_o.data  = int'(bus.o_data);
        mon_o.user  = int'(bus.o_user);
        mon_o.gray  = int'(bus.o_gray);
        mon_o.clamp = int'(bus.o_clamp);
        obs_q.push_back(mon_o);
        obs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got data %0d user %0d, required no output",
                   mon_o.data, mon_o.user);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_data",  mon_o.data,  mon_e.data);
          check("sb_user",  mon_o.user,  mon_e.user);
          check("sb_gray",  mon_o.gray,  mon_e.gray);
          check("sb_clamp", mon_o.clamp, mon_e.clamp);
        end
      end
      if (bus.i_valid && bus.o_ready) begin
        exp_q.push_back(model(int'($signed(bus.i_data)), int'(bus.i_function), int'(bus.i_user)));
      end
      prev_stall = bus.o_valid && !bus.i_ready;
      prev_data  = bus.o_data;
      prev_user  = bus.o_user;
      prev_gray  = bus.o_gray;
      prev_clamp = bus.o_clamp;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int d, int fn, int u);
    bit took;
    int n;
    n              = 0;
    bus.i_data     = DATA_W'(d);
    bus.i_function = 2'(fn);
    bus.i_user     = USER_W'(u);
    bus.i_valid    = 1'b1;
    do begin
      @(negedge clk);
      took = bus.o_ready;
      tick();
      n++;
    end while (!took && n < 50);
    if (!took) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got no o_ready in %0d cycles, required acceptance", n);
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_valid(string name);
    int n;
    n = 0;
    while (!bus.o_valid && n < 50) begin
      tick();
      n++;
    end
    if (!bus.o_valid) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got o_valid 0 after %0d cycles, required 1", name, n);
    end
  endtask

  task automatic drain();
    repeat (8) tick();
  endtask

  int base;
  bit saw_low;

  initial begin
    bus.i_data     = '0;
    bus.i_function = '0;
    bus.i_user     = '0;
    bus.i_valid    = 1'b0;
    bus.i_ready    = 1'b1;
`ifdef HUE_STAGE2_STATS_EN
    clr_stats      = 1'b0;
`endif
    rstn = 1'b0;
    repeat (3) tick();
    check("rst_o_valid", int'(bus.o_valid), 0);
    check("rst_o_data",  int'(bus.o_data),  0);
    check("rst_o_user",  int'(bus.o_user),  0);
    check("rst_o_gray",  int'(bus.o_gray),  0);
    check("rst_o_clamp", int'(bus.o_clamp), 0);
    rstn = 1'b1;
    tick();
    check("rst_o_ready", int'(bus.o_ready), 1);

    // Latency: transfer edge, then o_valid rises on the third edge
    send(32, 1, 8'hA5);
    check("lat_c1_valid", int'(bus.o_valid), 0);
    tick();
    check("lat_c2_valid", int'(bus.o_valid), 0);
    tick();
    check("lat_c3_valid", int'(bus.o_valid), 1);
    check("lat_data",  int'(bus.o_data),  30);
    check("lat_gray",  int'(bus.o_gray),  0);
    check("lat_clamp", int'(bus.o_clamp), 0);
    check("lat_user",  int'(bus.o_user),  8'hA5);
    tick();
    check("lat_single", int'(bus.o_valid), 0);

    // Wrap and sector offsets, back-to-back
    base = obs_q.size();
    send(-32, 1, 1);
    send(-64, 2, 2);
    send(64, 3, 3);
    send(-1, 1, 4);
    drain();
    check("wrap_count", obs_q.size() - base, 4);
    if (obs_q.size() >= base + 4) begin
      check("wrap_330", obs_q[base].data,   330);
      check("wrap_60",  obs_q[base+1].data, 60);
      check("wrap_300", obs_q[base+2].data, 300);
      check("wrap_359", obs_q[base+3].data, 359);
      check("wrap_consecutive", obs_cyc[base+3] - obs_cyc[base], 3);
    end

    // Clamp and gray flags
    base = obs_q.size();
    send(100, 1, 10);
    send(-500, 3, 11);
    send(17, 0, 12);
    drain();
    check("flag_count", obs_q.size() - base, 3);
    if (obs_q.size() >= base + 3) begin
      check("flag_hi_data",   obs_q[base].data,    60);
      check("flag_hi_clamp",  obs_q[base].clamp,   1);
      check("flag_lo_data",   obs_q[base+1].data,  180);
      check("flag_lo_clamp",  obs_q[base+1].clamp, 1);
      check("flag_gray_data", obs_q[base+2].data,  0);
      check("flag_gray_gray", obs_q[base+2].gray,  1);
      check("flag_gray_clamp", obs_q[base+2].clamp, 0);
    end

    // Backpressure: stall downstream for 5 cycles after the first output
    base    = obs_q.size();
    saw_low = 1'b0;
    fork
      begin
        for (int u = 0; u < 6; u++) send(16 * u - 40, (u % 3) + 1, u);
      end
      begin
        wait_valid("bp");
        bus.i_ready = 1'b0;
        repeat (5) begin
          tick();
          if (!bus.o_ready) saw_low = 1'b1;
        end
        bus.i_ready = 1'b1;
      end
    join
    drain();
    check("bp_ready_dropped", int'(saw_low), 1);
    check("bp_count", obs_q.size() - base, 6);
    if (obs_q.size() >= base + 6) begin
      for (int k = 0; k < 6; k++) check("bp_user_order", obs_q[base+k].user, k);
    end

    // Asynchronous reset with samples in flight
    send(10, 1, 20);
    send(20, 2, 21);
    send(30, 3, 22);
    rstn = 1'b0;
    #1;
    check("midrst_valid", int'(bus.o_valid), 0);
    base = obs_q.size();
    tick();
    tick();
    rstn = 1'b1;
    repeat (5) tick();
    check("midrst_no_stale", obs_q.size() - base, 0);
    send(32, 2, 23);
    drain();
    check("midrst_next_count", obs_q.size() - base, 1);
    if (obs_q.size() >= base + 1) check("midrst_next_data", obs_q[base].data, 150);

`ifdef HUE_STAGE2_STATS_EN
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("stats_clr_gray",  int'(gray_cnt),  0);
    check("stats_clr_clamp", int'(clamp_cnt), 0);
    send(5, 0, 30);
    send(-5, 0, 31);
    send(200, 0, 32);
    send(65, 1, 33);
    send(-65, 2, 34);
    drain();
    check("stats_gray",  int'(gray_cnt),  3);
    check("stats_clamp", int'(clamp_cnt), 2);
    send(0, 0, 35);
    wait_valid("stats");
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("stats_clr_prio", int'(gray_cnt), 0);
    drain();
`endif

    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200us, required finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
